// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared constants and helper types for the fetch queue
package if_fetch_queue_pkg;

  localparam int          ADDRESS_LEN     = 32;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          FQ_DEPTH        = 4;

  // Per-cycle queue operation, used to steer the occupancy update
  typedef enum logic [1:0] {
    FQ_IDLE = 2'b00,
    FQ_PUSH = 2'b01,
    FQ_POP  = 2'b10,
    FQ_BOTH = 2'b11
  } fq_op_e;

  function automatic fq_op_e fq_op(input logic push, input logic pop);
    return fq_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - fetch queue entry array, one write port and one async read port
module fq_storage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // Data is never reset; validity is tracked by the parent's count
  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry when the parent accepts a push
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - IF-to-ID instruction fetch queue; optional FETCH_QUEUE_BYPASS_EN empty-queue bypass
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int ADDR_W  = ADDRESS_LEN,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       freeze,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [ADDR_W-1:0]          pc_in,
  input  logic [INSTR_W-1:0]         instruction_in,
  output logic                       pop_valid,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [INSTR_W-1:0]         instruction_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int             PW   = $clog2(DEPTH);
  localparam int             CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_W-1:0]     head_pc;
  logic [INSTR_W-1:0]    head_instr;
  logic                  not_empty;
  logic                  bypass;
  logic                  push_fire;
  logic                  pop_fire;

  assign not_empty  = (count != '0);
  assign push_ready = (count != FULL);
  assign pop_fire   = not_empty & ~freeze & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming entry straight to decode; it is
  // only stored if decode is frozen and cannot take it this cycle.
  assign bypass    = ~rst & ~not_empty & push_valid & ~flush;
  assign push_fire = push_valid & push_ready & ~flush & ~(bypass & ~freeze);
`else
  assign bypass    = 1'b0;
  assign push_fire = push_valid & push_ready & ~flush;
`endif

  fq_storage #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_ptr),
    .wdata ({pc_in, instruction_in}),
    .raddr (rd_ptr),
    .rdata ({head_pc, head_instr})
  );

  // Pointers and occupancy; flush and reset both return the queue to empty
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
      case (fq_op(push_fire, pop_fire))
        FQ_PUSH: count <= count + CW'(1);
        FQ_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head presentation: stored head, bypassed input, or NOP when empty
  always_comb begin
    pop_valid       = not_empty;
    pc_out          = '0;
    instruction_out = INSTR_W'(NOP_INSTRUCTION);
    if (not_empty) begin
      pc_out          = head_pc;
      instruction_out = head_instr;
    end else if (bypass) begin
      pop_valid       = 1'b1;
      pc_out          = pc_in;
      instruction_out = instruction_in;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue (DEPTH=4)
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] pc_in = '0;
  logic [31:0] instruction_in = '0;
  logic        pop_valid;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [2:0]  count;

  int          n_vec = 0;
  int          n_err = 0;
  int          mcount = 0;
  logic [31:0] sb[$];

  if_fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .freeze          (freeze),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .pop_valid       (pop_valid),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .count           (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected-queue model advances at the edge
  task automatic drive(input logic pv, input logic [31:0] pc, input logic frz, input logic fl);
    logic push_ok;
    logic pop_ok;
    push_valid     = pv;
    pc_in          = pc;
    instruction_in = instr_of(pc);
    freeze         = frz;
    flush          = fl;
    @(posedge clk);
    push_ok = pv && (mcount != DEPTH) && !fl;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (mcount == 0 && !frz) push_ok = 1'b0;
`endif
    pop_ok = (mcount != 0) && !frz && !fl;
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (push_ok) sb.push_back(pc);
      mcount = mcount + int'(push_ok) - int'(pop_ok);
    end
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    push_valid = 1'b0;
    freeze     = 1'b0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
    mcount = 0;
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares the head against the scoreboard and retires popped entries
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_pv;
      logic byp;
      exp_pv = (mcount != 0);
      byp    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = (mcount == 0) && push_valid && !flush;
      if (byp) exp_pv = 1'b1;
`endif
      check("count", 64'(count), 64'(mcount));
      check("push_ready", 64'(push_ready), 64'(mcount != DEPTH));
      check("pop_valid", 64'(pop_valid), 64'(exp_pv));
      if (byp) begin
        check("bypass_pc", 64'(pc_out), 64'(pc_in));
        check("bypass_instr", 64'(instruction_out), 64'(instruction_in));
      end else if (exp_pv) begin
        if (sb.size() == 0) begin
          check("scoreboard_nonempty", 64'(0), 64'(1));
        end else begin
          check("head_pc", 64'(pc_out), 64'(sb[0]));
          check("head_instr", 64'(instruction_out), 64'(instr_of(sb[0])));
          if (!freeze && !flush) void'(sb.pop_front());
        end
      end else begin
        check("empty_pc", 64'(pc_out), 64'(0));
        check("empty_instr", 64'(instruction_out), 64'(NOP));
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_count", 64'(count), 64'(0));
    check("rst_pop_valid", 64'(pop_valid), 64'(0));
    check("rst_push_ready", 64'(push_ready), 64'(1));
    check("rst_instr", 64'(instruction_out), 64'(NOP));

    // Fill while frozen; fifth push must be ignored
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
    check("full_count", 64'(count), 64'(4));
    check("full_push_ready", 64'(push_ready), 64'(0));
    check("full_head", 64'(pc_out), 64'(0));
    drive(1'b1, 32'd16, 1'b1, 1'b0);
    check("full_reject_count", 64'(count), 64'(4));

    // Full + pop: push rejected, count drops to 3, head advances
    drive(1'b1, 32'd16, 1'b0, 1'b0);
    check("fullpop_count", 64'(count), 64'(3));
    check("fullpop_head", 64'(pc_out), 64'(4));
    drive(1'b1, 32'd16, 1'b1, 1'b0);
    check("refill_count", 64'(count), 64'(4));
    repeat (5) drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("drained_count", 64'(count), 64'(0));

    // Streaming through with pointer wrap
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      check("stream_head", 64'(pc_out), 64'(4 * i));
    end
    repeat (2) drive(1'b0, 32'd0, 1'b0, 1'b0);

    // Flush with a concurrent push (and freeze) drops everything
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    drive(1'b1, 32'h104, 1'b1, 1'b0);
    drive(1'b1, 32'h108, 1'b1, 1'b0);
    check("preflush_count", 64'(count), 64'(3));
    drive(1'b1, 32'h10C, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'(0));
    check("flush_pop_valid", 64'(pop_valid), 64'(0));
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("postflush_count", 64'(count), 64'(0));

    // Reset mid-operation empties the queue
    drive(1'b1, 32'h200, 1'b1, 1'b0);
    drive(1'b1, 32'h204, 1'b1, 1'b0);
    do_reset();
    check("midrst_count", 64'(count), 64'(0));
    check("midrst_pc", 64'(pc_out), 64'(0));

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty-queue bypass is visible in the same cycle and stores nothing
    push_valid     = 1'b1;
    pc_in          = 32'h40;
    instruction_in = instr_of(32'h40);
    freeze         = 1'b0;
    flush          = 1'b0;
    #2;
    check("byp_pop_valid", 64'(pop_valid), 64'(1));
    check("byp_pc", 64'(pc_out), 64'(32'h40));
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    check("byp_count", 64'(count), 64'(0));
    drive(1'b0, 32'd0, 1'b0, 1'b0);
`endif

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
